cnt_wrap_monitor: RTL and testbench
===================================

CNT_WRAP_MONITOR -- requirements
Module: cnt_wrap_monitor

Interface
REQ-001 The block SHALL have parameter IN_SIZE, default 2: width of the monitored divider count.
REQ-002 The block SHALL have parameter IN_MAX, default 2'b11: terminal value of the monitored count.
REQ-003 The block SHALL have parameter WRAP_CNT_SIZE, default 8: width of the wrap counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: the same enable that drives the upstream divider.
REQ-007 The block SHALL have port in, input, IN_SIZE bits: the divider count output.
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous clear.
REQ-009 The block SHALL have port step_pulse, output, 1 bit: one-cycle pulse per legal count advance.
REQ-010 The block SHALL have port wrap_pulse, output, 1 bit: one-cycle pulse per IN_MAX->0 advance.
REQ-011 The block SHALL have port wrap_count, output, WRAP_CNT_SIZE bits: saturating count of wraps.
REQ-012 The block SHALL have port sat, output, 1 bit: high while wrap_count is all ones.
REQ-013 The block SHALL have port fault, output, 1 bit: sticky flag for an illegal count sequence.
REQ-014 The block SHALL have port state, output, 2 bits: FSM state, encoded IDLE=00, TRACK=01, FAULT=10.

Function
REQ-015 All outputs SHALL be registered; in SHALL be registered into in_q each cycle while in TRACK.
REQ-016 IDLE: capture in into in_q; move to TRACK on the next edge when clr=0; no pulses.
REQ-017 TRACK, en=1, in==in_q: hold; no pulses.
REQ-018 TRACK, en=1, in_q<IN_MAX, in==in_q+1: step_pulse=1 for exactly the cycle after the edge that first samples the new value.
REQ-019 TRACK, en=1, in_q==IN_MAX, in==0: step_pulse=1 and wrap_pulse=1 in the same cycle; wrap_count increments by 1.
REQ-020 wrap_count SHALL saturate at 2^WRAP_CNT_SIZE-1 with no wrap-around; sat=1 from then on; wrap_pulse SHALL still pulse on each further wrap.
REQ-021 TRACK, en=0, in==in_q: hold; no pulses.
REQ-022 Any other TRACK condition SHALL set fault=1 and move to FAULT on the same edge: any jump other than +1 or IN_MAX->0, in>IN_MAX, or in!=in_q while en=0.
REQ-023 FAULT: step_pulse=0, wrap_pulse=0; wrap_count and in_q frozen; fault stays 1 until clr or reset.
REQ-024 clr=1 SHALL take priority in every state. On the next edge: state IDLE, wrap_count=0, sat=0, fault=0, pulses 0.
REQ-025 A pulse SHALL never exceed one cycle, even if in holds its new value for many cycles.

Reset
REQ-026 reset=0 SHALL immediately force state=IDLE, in_q=0, wrap_count=0, sat=0, fault=0, step_pulse=0, wrap_pulse=0, independent of clk.
REQ-027 Assertion of reset mid-operation SHALL discard all history; after release, behaviour SHALL match REQ-016.

Verification
REQ-028 The bench SHALL use IN_MAX=3, WRAP_CNT_SIZE=4 for the scenarios below.
REQ-029 Reset low for 10 ns, then released, with in=0 and en=1 -> all outputs 0, state=00; state=01 after one clk edge.
REQ-030 in stepped 0,1,2,3,0, each value held 2 cycles, en=1 -> 4 step_pulses of one cycle each, 1 wrap_pulse coincident with the 4th step_pulse, wrap_count=1.
REQ-031 17 full wraps -> wrap_count=15 and sat=1 after the 15th wrap; wrap_pulse still seen on wraps 16 and 17; wrap_count stays 15.
REQ-032 in jumps 1->3 -> fault=1 and state=10 one cycle later, wrap_count frozen; clr for one cycle -> state=00, fault=0, wrap_count=0.
REQ-033 en=0 for 30 cycles with in held at 2 -> no pulses and no fault; in changed to 3 while en=0 -> fault=1.
REQ-034 reset asserted between clk edges in TRACK with wrap_count=5 -> wrap_count=0 and state=00 before the next clk edge.

Source files
------------

// File: rtl/cnt_wrap_monitor.sv
// Watches a free-running divider count, pulses on each legal advance and on each
// terminal->zero wrap, keeps a saturating wrap tally and latches any illegal sequence.
module cnt_wrap_monitor #(
    parameter int unsigned                IN_SIZE       = 2,
    parameter logic [IN_SIZE-1:0]         IN_MAX        = 2'b11,
    parameter int unsigned                WRAP_CNT_SIZE = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [IN_SIZE-1:0]       in,
    input  logic                     clr,
    output logic                     step_pulse,
    output logic                     wrap_pulse,
    output logic [WRAP_CNT_SIZE-1:0] wrap_count,
    output logic                     sat,
    output logic                     fault,
    output logic [1:0]               state
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_TRACK = 2'b01;
    localparam logic [1:0] ST_FAULT = 2'b10;

    logic [1:0]               r_state;
    logic [IN_SIZE-1:0]       r_in_q;
    logic [WRAP_CNT_SIZE-1:0] r_wrap_count;
    logic                     r_sat;
    logic                     r_fault;
    logic                     r_step;
    logic                     r_wrap;

    logic [IN_SIZE:0]         w_in_inc;
    logic                     w_in_range;
    logic                     w_hold;
    logic                     w_step;
    logic                     w_wrap;
    logic                     w_bad;
    logic [WRAP_CNT_SIZE-1:0] w_cnt_next;

    function automatic logic [WRAP_CNT_SIZE-1:0] sat_inc(input logic [WRAP_CNT_SIZE-1:0] c);
        if (&c) begin
            return c;
        end
        return c + {{(WRAP_CNT_SIZE-1){1'b0}}, 1'b1};
    endfunction

    // Widened by one bit so in_q+1 cannot alias back to zero at the top of the range.
    assign w_in_inc   = {1'b0, r_in_q} + {{IN_SIZE{1'b0}}, 1'b1};
    assign w_in_range = (in <= IN_MAX);

    always_comb begin
        w_hold = w_in_range && (in == r_in_q);
        w_step = en && w_in_range && (r_in_q < IN_MAX) && ({1'b0, in} == w_in_inc);
        w_wrap = en && (r_in_q == IN_MAX) && (in == {IN_SIZE{1'b0}});
        w_bad  = !(w_hold || w_step || w_wrap);
    end

    assign w_cnt_next = sat_inc(r_wrap_count);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_in_q       <= {IN_SIZE{1'b0}};
            r_wrap_count <= {WRAP_CNT_SIZE{1'b0}};
            r_sat        <= 1'b0;
            r_fault      <= 1'b0;
            r_step       <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_step <= 1'b0;
            r_wrap <= 1'b0;
            if (clr) begin
                r_state      <= ST_IDLE;
                r_in_q       <= in;
                r_wrap_count <= {WRAP_CNT_SIZE{1'b0}};
                r_sat        <= 1'b0;
                r_fault      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_in_q  <= in;
                        r_state <= ST_TRACK;
                    end
                    ST_TRACK: begin
                        // An illegal sample is not taken into in_q, so the last good count is kept.
                        if (w_bad) begin
                            r_fault <= 1'b1;
                            r_state <= ST_FAULT;
                        end else begin
                            r_in_q <= in;
                            r_step <= w_step || w_wrap;
                            if (w_wrap) begin
                                r_wrap       <= 1'b1;
                                r_wrap_count <= w_cnt_next;
                                r_sat        <= &w_cnt_next;
                            end
                        end
                    end
                    ST_FAULT: begin
                        r_state <= ST_FAULT;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign step_pulse = r_step;
    assign wrap_pulse = r_wrap;
    assign wrap_count = r_wrap_count;
    assign sat        = r_sat;
    assign fault      = r_fault;
    assign state      = r_state;

endmodule

// File: tb/tb_cnt_wrap_monitor.sv
// Directed bench for cnt_wrap_monitor with IN_MAX=3 and a 4-bit wrap counter.
module tb_cnt_wrap_monitor;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] in;
    logic       clr;
    logic       step_pulse;
    logic       wrap_pulse;
    logic [3:0] wrap_count;
    logic       sat;
    logic       fault;
    logic [1:0] state;

    int n_vec;
    int n_err;

    // Observed word: {state, fault, sat, wrap_count, wrap_pulse, step_pulse}
    logic [9:0] obs;
    assign obs = {state, fault, sat, wrap_count, wrap_pulse, step_pulse};

    cnt_wrap_monitor #(
        .IN_SIZE      (2),
        .IN_MAX       (2'b11),
        .WRAP_CNT_SIZE(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in        (in),
        .clr       (clr),
        .step_pulse(step_pulse),
        .wrap_pulse(wrap_pulse),
        .wrap_count(wrap_count),
        .sat       (sat),
        .fault     (fault),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        reset = 1'b0;
        en    = 1'b1;
        in    = 2'd0;
        clr   = 1'b0;
        #10;
        exp = 10'b00_0_0_0000_0_0;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL reset_held: got %b expected %b", obs, exp);
        end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL reset_released: got %b expected %b", obs, exp);
        end
        tick();
        exp = 10'b01_0_0_0000_0_0;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL reset_to_track: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_step_wrap();
        logic [1:0] vals [4];
        logic [9:0] exp;
        int         n_step;
        int         n_wrap;
        vals   = '{2'd1, 2'd2, 2'd3, 2'd0};
        n_step = 0;
        n_wrap = 0;
        for (int i = 0; i < 4; i++) begin
            in = vals[i];
            tick();
            n_step += int'(step_pulse);
            n_wrap += int'(wrap_pulse);
            exp = {2'b01, 1'b0, 1'b0, (i == 3) ? 4'd1 : 4'd0, (i == 3), 1'b1};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL step_edge[%0d]: got %b expected %b", i, obs, exp);
            end
            tick();
            n_step += int'(step_pulse);
            n_wrap += int'(wrap_pulse);
            exp = {2'b01, 1'b0, 1'b0, (i == 3) ? 4'd1 : 4'd0, 1'b0, 1'b0};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL step_hold[%0d]: got %b expected %b", i, obs, exp);
            end
        end
        n_vec++;
        if (n_step != 4 || n_wrap != 1) begin
            n_err++;
            $display("FAIL step_totals: got steps=%0d wraps=%0d expected steps=4 wraps=1", n_step, n_wrap);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] vals [4];
        logic [9:0] exp;
        int         c_before;
        int         c_after;
        vals = '{2'd1, 2'd2, 2'd3, 2'd0};
        in   = 2'd0;
        clr  = 1'b1;
        tick();
        exp = 10'b00_0_0_0000_0_0;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL sat_clr: got %b expected %b", obs, exp);
        end
        clr = 1'b0;
        tick();
        for (int k = 1; k <= 17; k++) begin
            c_before = (k - 1 > 15) ? 15 : k - 1;
            c_after  = (k > 15) ? 15 : k;
            for (int i = 0; i < 4; i++) begin
                in = vals[i];
                tick();
                if (i == 3) begin
                    exp = {2'b01, 1'b0, (c_after == 15), 4'(c_after), 1'b1, 1'b1};
                end else begin
                    exp = {2'b01, 1'b0, (c_before == 15), 4'(c_before), 1'b0, 1'b1};
                end
                n_vec++;
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL sat_wrap%0d_step%0d: got %b expected %b", k, i, obs, exp);
                end
                tick();
            end
        end
    endtask

    task automatic test_fault();
        logic [9:0] exp;
        in = 2'd1;
        tick();
        exp = 10'b01_0_1_1111_0_1;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL fault_pre_step: got %b expected %b", obs, exp);
        end
        in = 2'd3;
        tick();
        exp = 10'b10_1_1_1111_0_0;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL fault_jump: got %b expected %b", obs, exp);
        end
        in = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL fault_frozen[%0d]: got %b expected %b", i, obs, exp);
            end
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp = 10'b00_0_0_0000_0_0;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL fault_clr: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_en_low();
        logic [9:0] exp;
        int         bad;
        in = 2'd2;
        tick();
        exp = 10'b01_0_0_0000_0_0;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL enlow_track: got %b expected %b", obs, exp);
        end
        en  = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (obs !== exp) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL enlow_hold: got %0d deviating cycles expected 0 (last %b vs %b)", bad, obs, exp);
        end
        in = 2'd3;
        tick();
        exp = 10'b10_1_0_0000_0_0;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL enlow_change: got %b expected %b", obs, exp);
        end
        en  = 1'b1;
        in  = 2'd0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [1:0] vals [4];
        logic [9:0] exp;
        vals = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) begin
                in = vals[i];
                tick();
                tick();
            end
        end
        exp = 10'b01_0_0_0101_0_0;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL mid_pre: got %b expected %b", obs, exp);
        end
        #2;
        reset = 1'b0;
        #1;
        exp = 10'b00_0_0_0000_0_0;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL mid_async: got %b expected %b", obs, exp);
        end
        reset = 1'b1;
        tick();
        exp = 10'b01_0_0_0000_0_0;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL mid_restart: got %b expected %b", obs, exp);
        end
        in = 2'd1;
        tick();
        exp = 10'b01_0_0_0000_0_1;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL mid_first_step: got %b expected %b", obs, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_step_wrap();
        test_saturation();
        test_fault();
        test_en_low();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
